physics_step_scheduler: RTL and testbench



---
 rtl/physics_step_scheduler.sv | 116 +++++++++++
 tb/tb_physics_step_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/physics_step_scheduler.sv
// Frame-rate scheduler: divides the pixel clock to the physics rate and, on each
// accepted frame tick, runs player-1, player-2 and ball step units in sequence.
module physics_step_scheduler #(
  parameter int unsigned SRC_FREQ = 65_000_000,
  parameter int unsigned FREQ     = 100,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        p1_done,
  input  logic        p2_done,
  input  logic        ball_done,
  output logic        p1_start,
  output logic        p2_start,
  output logic        ball_start,
  output logic        frame_tick,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned DIV   = SRC_FREQ / FREQ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE, P1_START, P1_WAIT, P2_START, P2_WAIT, B_START, B_WAIT, FRAME_END
  } state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  div_cnt, div_d;
  logic [TO_W-1:0]   wait_cnt;
  logic              in_wait_c;
  logic              done_sel_c;
  logic              wait_last_c;
  logic              set_timeout_c;
  logic              set_overrun_c;

  // Free-running divider; the tick output is registered one step ahead
  always_comb begin
    div_d = (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
  end

  always_comb begin
    state_d       = state;
    in_wait_c     = 1'b0;
    done_sel_c    = 1'b0;
    wait_last_c   = (wait_cnt == TO_W'(TIMEOUT - 1));
    set_timeout_c = 1'b0;
    set_overrun_c = frame_tick && (state != IDLE);
    case (state)
      IDLE:      if (frame_tick && !pause) state_d = P1_START;
      P1_START:  state_d = P1_WAIT;
      P1_WAIT: begin
        in_wait_c  = 1'b1;
        done_sel_c = p1_done;
        if (p1_done || wait_last_c) state_d = P2_START;
      end
      P2_START:  state_d = P2_WAIT;
      P2_WAIT: begin
        in_wait_c  = 1'b1;
        done_sel_c = p2_done;
        if (p2_done || wait_last_c) state_d = B_START;
      end
      B_START:   state_d = B_WAIT;
      B_WAIT: begin
        in_wait_c  = 1'b1;
        done_sel_c = ball_done;
        if (ball_done || wait_last_c) state_d = FRAME_END;
      end
      FRAME_END: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // A done in the last allowed cycle still counts as a normal completion
    set_timeout_c = in_wait_c && wait_last_c && !done_sel_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_d;
      wait_cnt <= in_wait_c ? wait_cnt + TO_W'(1) : '0;
    end
  end

  // Outputs registered from next-state values so they align with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_start    <= 1'b0;
      p2_start    <= 1'b0;
      ball_start  <= 1'b0;
      frame_tick  <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      p1_start   <= (state_d == P1_START);
      p2_start   <= (state_d == P2_START);
      ball_start <= (state_d == B_START);
      frame_tick <= (div_d == DIV_W'(DIV - 1));
      busy       <= (state_d != IDLE);
      if (state == FRAME_END) frame_cnt <= frame_cnt + CNT_W'(1);
      if (set_overrun_c) overrun <= 1'b1;
      if (set_timeout_c) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_physics_step_scheduler.sv
// Bench for physics_step_scheduler: directed and random segments checked each cycle
// against a frame-level schedule computed from tick times and done windows.
module tb_physics_step_scheduler;

  localparam int unsigned SRC_FREQ = 1000;
  localparam int unsigned FREQ     = 100;
  localparam int unsigned TIMEOUT  = 8;
  localparam int DIV  = int'(SRC_FREQ / FREQ);
  localparam int TO   = int'(TIMEOUT);
  localparam int MAXC = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        p1_done = 1'b0;
  logic        p2_done = 1'b0;
  logic        ball_done = 1'b0;
  logic        p1_start, p2_start, ball_start, frame_tick, busy, overrun, timeout_err;
  logic [15:0] frame_cnt;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  bit          st_pause [MAXC];
  bit          st_d     [3][MAXC];
  bit          e_start  [3][MAXC];
  bit          e_tick   [MAXC];
  bit          e_busy   [MAXC];
  bit          e_ovr    [MAXC];
  bit          e_err    [MAXC];
  logic [15:0] e_cnt    [MAXC];

  physics_step_scheduler #(
    .SRC_FREQ(SRC_FREQ), .FREQ(FREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .p1_done(p1_done), .p2_done(p2_done), .ball_done(ball_done),
    .p1_start(p1_start), .p2_start(p2_start), .ball_start(ball_start),
    .frame_tick(frame_tick), .busy(busy), .frame_cnt(frame_cnt),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic clear_stim(input bit pause_dflt);
    for (int c = 0; c < MAXC; c++) begin
      st_pause[c] = pause_dflt;
      for (int u = 0; u < 3; u++) st_d[u][c] = 1'b0;
    end
  endtask

  // Schedule model: each accepted tick launches three units in turn; each unit's
  // done is looked for in the TIMEOUT-cycle window after its start pulse.
  task automatic build_model(input int n, input logic [15:0] base);
    int free_from, ovr_at, err_at, start, w, done_at, fe;
    int inc [MAXC];
    logic [15:0] cnt;
    free_from = 0;
    ovr_at    = MAXC;
    err_at    = MAXC;
    for (int c = 0; c < MAXC; c++) begin
      inc[c] = 0; e_tick[c] = 1'b0; e_busy[c] = 1'b0;
      for (int u = 0; u < 3; u++) e_start[u][c] = 1'b0;
    end
    for (int c = 0; c < n; c++) begin
      if (c % DIV == DIV - 1) begin
        e_tick[c] = 1'b1;
        if (c < free_from) begin
          if (c + 1 < ovr_at) ovr_at = c + 1;
        end else if (!st_pause[c]) begin
          start = c + 1;
          for (int u = 0; u < 3; u++) begin
            if (start < MAXC) e_start[u][start] = 1'b1;
            w = start + 1;
            done_at = -1;
            for (int k = w; k < w + TO && k < MAXC; k++)
              if (done_at < 0 && st_d[u][k]) done_at = k;
            if (done_at < 0) begin
              start = w + TO;
              if (start < err_at) err_at = start;
            end else begin
              start = done_at + 1;
            end
          end
          fe = start;
          for (int k = c + 1; k <= fe && k < MAXC; k++) e_busy[k] = 1'b1;
          if (fe + 1 < MAXC) inc[fe + 1]++;
          free_from = fe + 1;
        end
      end
    end
    cnt = base;
    for (int c = 0; c < MAXC; c++) begin
      cnt      = cnt + 16'(inc[c]);
      e_cnt[c] = (c == 0) ? 16'h0000 : cnt;
      e_ovr[c] = (c >= ovr_at);
      e_err[c] = (c >= err_at);
    end
  endtask

  task automatic check_reset(input int r);
    chk("rst_p1_start", r, 16'(p1_start), 16'h0);
    chk("rst_p2_start", r, 16'(p2_start), 16'h0);
    chk("rst_ball_start", r, 16'(ball_start), 16'h0);
    chk("rst_frame_tick", r, 16'(frame_tick), 16'h0);
    chk("rst_busy", r, 16'(busy), 16'h0);
    chk("rst_frame_cnt", r, frame_cnt, 16'h0);
    chk("rst_overrun", r, 16'(overrun), 16'h0);
    chk("rst_timeout_err", r, 16'(timeout_err), 16'h0);
  endtask

  task automatic check_cycle(input int c);
    chk("p1_start", c, 16'(p1_start), 16'(e_start[0][c]));
    chk("p2_start", c, 16'(p2_start), 16'(e_start[1][c]));
    chk("ball_start", c, 16'(ball_start), 16'(e_start[2][c]));
    chk("frame_tick", c, 16'(frame_tick), 16'(e_tick[c]));
    chk("busy", c, 16'(busy), 16'(e_busy[c]));
    chk("frame_cnt", c, frame_cnt, e_cnt[c]);
    chk("overrun", c, 16'(overrun), 16'(e_ovr[c]));
    chk("timeout_err", c, 16'(timeout_err), 16'(e_err[c]));
  endtask

  // Three reset cycles, then n cycles of the prepared stimulus, checked every cycle
  task automatic run_segment(input int n, input logic [15:0] base, input bit do_wrap);
    build_model(n, base);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      if (r > 0) check_reset(r);
      rst = 1'b1; pause = 1'b0; p1_done = 1'b0; p2_done = 1'b0; ball_done = 1'b0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_cycle(c);
      if (do_wrap && c == 0) dut.frame_cnt = base;
      rst       = 1'b0;
      pause     = st_pause[c];
      p1_done   = st_d[0][c];
      p2_done   = st_d[1][c];
      ball_done = st_d[2][c];
    end
  endtask

  initial begin
    // Divider with pause held high; random dones must be ignored
    clear_stim(1'b1);
    for (int c = 0; c < 35; c++)
      for (int u = 0; u < 3; u++) st_d[u][c] = ($urandom_range(3) == 0);
    run_segment(35, 16'h0000, 1'b0);

    // Normal frame, dones 2 cycles after each start, stray dones in P1_WAIT
    clear_stim(1'b1);
    st_pause[9] = 1'b0;
    st_d[2][11] = 1'b1;
    st_d[1][11] = 1'b1;
    st_d[0][12] = 1'b1;
    st_d[1][15] = 1'b1;
    st_d[2][18] = 1'b1;
    run_segment(30, 16'h0000, 1'b0);

    // Player-2 never finishes: timeout, frame still completes
    clear_stim(1'b1);
    st_pause[9] = 1'b0;
    st_d[0][11] = 1'b1;
    st_d[2][22] = 1'b1;
    run_segment(40, 16'h0000, 1'b0);

    // Slow units stretch the frame across the next tick
    clear_stim(1'b1);
    st_pause[9]  = 1'b0;
    st_pause[19] = 1'b0;
    st_d[0][17]  = 1'b1;
    st_d[1][25]  = 1'b1;
    for (int c = 0; c < MAXC; c++) st_d[2][c] = 1'b1;
    run_segment(45, 16'h0000, 1'b0);

    // Frame abandoned by a reset during P2_WAIT
    clear_stim(1'b1);
    st_pause[9] = 1'b0;
    st_d[0][11] = 1'b1;
    run_segment(16, 16'h0000, 1'b0);

    // Random pause and done traffic
    clear_stim(1'b0);
    for (int c = 0; c < 300; c++) begin
      st_pause[c] = ($urandom_range(3) == 0);
      for (int u = 0; u < 3; u++) st_d[u][c] = ($urandom_range(3) == 0);
    end
    run_segment(300, 16'h0000, 1'b0);

    // Frame counter wrap with level dones
    clear_stim(1'b1);
    st_pause[9] = 1'b0;
    for (int c = 0; c < MAXC; c++)
      for (int u = 0; u < 3; u++) st_d[u][c] = 1'b1;
    run_segment(30, 16'hFFFF, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
